seq_mult_ctrl: RTL and testbench
================================

// Module: seq_mult_ctrl
// PURPOSE
//  Control FSM for the shift-add sequential multiplier. Drives add_shift/shift into the step
//  counter and consumes its count_check terminal flag. Issues the load strobe to the datapath.
//  Provides a valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//  WIDTH_C  4  step-counter width; one operation = STEPS = 2**WIDTH_C add/shift steps (localparam)
// PORTS
//  clk            in   1        clock, rising edge
//  reset_n        in   1        asynchronous, active-low reset
//  in_valid       in   1        operands present on the datapath inputs
//  in_ready       out  1        controller idle and able to accept operands
//  multiplier_lsb in   1        LSB of the current multiplier shift register (datapath)
//  count_check    in   1        counter terminal flag, high when count == STEPS-1
//  load           out  1        one-cycle strobe: datapath captures operands, clears accumulator
//  add_shift      out  1        step with add: accumulate multiplicand, then shift
//  shift          out  1        step without add: shift only
//  out_valid      out  1        product valid on the datapath outputs
//  out_ready      in   1        consumer accepts the product
//  busy           out  1        high in LOAD and CALC
//  step_err       out  1        sticky step-alignment error (optional feature; otherwise tied 0)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; in_ready=1; all other outputs 0.
//  - States: IDLE -> LOAD -> CALC -> DONE -> IDLE.
//  - IDLE: in_ready=1. When in_valid=1 at a rising edge, go to LOAD. No other output is active.
//  - LOAD: one cycle. load=1, busy=1. Always goes to CALC.
//  - CALC: busy=1. Every cycle exactly one step output is high:
//      - add_shift=1 when multiplier_lsb=1.
//      - shift=1 when multiplier_lsb=0.
//  - add_shift and shift are never high together, and never high outside CALC.
//  - CALC exit: a step taken while count_check=1 is the last step; go to DONE on the next edge.
//    The counter wraps 15->0, so it is 0 at the next operation (no counter clear needed).
//  - DONE: out_valid=1 and held until out_ready=1. Product must stay stable while held.
//    On the out_valid&out_ready edge, go to IDLE.
//  - out_ready ignored outside DONE. in_valid ignored outside IDLE (in_ready=0).
//  - Latency, in_valid accepted at edge 0:
//      - load high in cycle 1.
//      - Steps in cycles 2..STEPS+1 (16 steps for WIDTH_C=4).
//      - out_valid first high in cycle STEPS+2.
//  - Back-to-back: accept in_valid at the earliest in the cycle after the DONE handshake (IDLE).
//  - Reset mid-operation: immediate return to IDLE, outputs cleared.
//    The counter shares reset_n, so both restart aligned.
//  - All outputs are registered or decoded from state only. No combinational path from
//    in_valid/out_ready to in_ready/out_valid.
// CONFIGURATION
//  SEQ_MULT_STEP_CHECK_EN defined:
//    - A shadow step counter (WIDTH_C bits) clears in LOAD and increments on each CALC step.
//    - step_err sets (sticky until reset_n) on either condition:
//        - count_check=1 while shadow != STEPS-1.
//        - count_check=0 on the step where shadow == STEPS-1.
//    - The FSM still exits on the count_check rule; step_err is report-only.
//  SEQ_MULT_STEP_CHECK_EN undefined: no shadow counter; step_err tied 0.
// TESTING
//  1. reset_n low mid-CALC -> same-time IDLE, add_shift=shift=busy=out_valid=0, in_ready=1.
//  2. Multiplier 16'hFFFF, in_valid pulse with counter model -> load at cycle 1;
//     add_shift high cycles 2..17; out_valid at cycle 18.
//  3. Multiplier 16'h0000 -> 16 shift pulses, zero add_shift; product 0.
//     Then 16'hA5A5 x 16'h0003 gives 32'h0001_F0EF.
//  4. out_ready held low 5 cycles in DONE -> out_valid held, product stable, no steps, in_ready=0.
//     Then out_ready=1 -> IDLE next edge.
//  5. Two back-to-back ops, in_valid held high -> second load exactly 2 cycles after
//     the first DONE handshake edge. Counter 0 at second CALC start.
//  6. (SEQ_MULT_STEP_CHECK_EN) force count_check=1 at step 8 -> step_err=1 next edge,
//     sticky until reset_n. Without the macro -> step_err stays 0.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
//
// Control FSM for a shift-add sequential multiplier. It sequences one
// multiplication as LOAD -> STEPS add/shift steps -> DONE. The step count is
// kept by an external counter, and the last step is flagged by that counter's
// count_check output. Operands are accepted, and the product is returned,
// through a valid/ready handshake.
//
// Optional feature (compile-time macro SEQ_MULT_STEP_CHECK_EN):
//   A shadow step counter cross-checks the external count_check flag. Any
//   misalignment sets a sticky step_err. The error is report-only, so the FSM
//   still leaves CALC on count_check. When the macro is undefined, step_err
//   is tied low.
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous assert, synchronous release, active low
//   in_valid       in   operands present on the datapath inputs
//   in_ready       out  controller idle and able to accept operands
//   multiplier_lsb in   LSB of the datapath multiplier shift register
//   count_check    in   external step counter is at its last value
//   load           out  one-cycle strobe: capture operands, clear accumulator
//   add_shift      out  step with add (accumulate multiplicand, then shift)
//   shift          out  step without add (shift only)
//   out_valid      out  product valid on the datapath outputs
//   out_ready      in   consumer accepts the product
//   busy           out  operation in progress (LOAD or CALC)
//   step_err       out  sticky step-alignment error (optional feature)
// ---------------------------------------------------------------------------
module seq_mult_ctrl (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic multiplier_lsb,
  input  logic count_check,
  output logic load,
  output logic add_shift,
  output logic shift,
  output logic out_valid,
  input  logic out_ready,
  output logic busy,
  output logic step_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: a default assignment at the top of every always_comb makes each
  // output fully specified on every path, which prevents latch inference.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)    state_next = LOAD;
      LOAD:                     state_next = CALC;
      // The step taken while count_check is high is the final one.
      CALC:    if (count_check) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  // The handshake outputs depend on state only, so in_valid and out_ready
  // never reach in_ready or out_valid combinationally. Within CALC, the step
  // type follows the datapath multiplier LSB of the current cycle.
  always_comb begin
    in_ready  = 1'b0;
    load      = 1'b0;
    add_shift = 1'b0;
    shift     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      CALC: begin
        busy      = 1'b1;
        add_shift = multiplier_lsb;
        shift     = ~multiplier_lsb;
      end
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_MULT_STEP_CHECK_EN
  // -------------------------------------------------------------------------
  // Shadow step counter and alignment check
  // -------------------------------------------------------------------------
  localparam int WIDTH_C = 4;
  localparam int STEPS   = 2 ** WIDTH_C;
  localparam logic [WIDTH_C-1:0] LAST_STEP = WIDTH_C'(STEPS - 1);

  logic [WIDTH_C-1:0] shadow_count;
  logic               step_err_q;
  logic               in_calc;

  assign in_calc = (state == CALC);

  // On every step, count_check must be high exactly when the shadow count
  // sits on the last step. A mismatch in either direction is an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_count <= '0;
      step_err_q   <= 1'b0;
    end else begin
      if (state == LOAD) begin
        shadow_count <= '0;
      end else if (in_calc) begin
        shadow_count <= shadow_count + 1'b1;
      end
      if (in_calc && (count_check != (shadow_count == LAST_STEP))) begin
        step_err_q <= 1'b1;
      end
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_ctrl
//
// Bench for seq_mult_ctrl. It surrounds the controller with a behavioural
// 4-bit step counter and a 16x16 shift-add datapath. Expected products are
// queued when operands are offered, then popped and compared when the
// controller presents out_valid. Controller outputs are sampled on the
// falling clock edge.
//
// Output vector order used in comparisons:
//   {in_ready, load, add_shift, shift, out_valid, busy, step_err}
// ---------------------------------------------------------------------------
module tb_seq_mult_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic multiplier_lsb;
  logic count_check;
  logic in_ready, load, add_shift, shift, out_valid, busy, step_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

`ifdef SEQ_MULT_STEP_CHECK_EN
  localparam logic STEP_ERR_EXP = 1'b1;
`else
  localparam logic STEP_ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_mult_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .multiplier_lsb (multiplier_lsb),
    .count_check    (count_check),
    .load           (load),
    .add_shift      (add_shift),
    .shift          (shift),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .step_err       (step_err)
  );

  // ---------------- external step counter and datapath model ----------------
  logic [3:0]  cnt;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [15:0] mcand = '0;
  logic [15:0] mplier = '0;
  logic [31:0] prod = '0;
  logic        force_cc = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= 4'd0;
    else if (add_shift || shift) cnt <= cnt + 4'd1;
  end

  always @(posedge clk) begin
    if (load) begin
      mcand  <= a_in;
      mplier <= b_in;
      prod   <= '0;
    end else if (add_shift || shift) begin
      if (add_shift) prod <= prod + ({16'd0, mcand} << cnt);
      mplier <= mplier >> 1;
    end
  end

  assign multiplier_lsb = mplier[0];
  assign count_check    = (cnt == 4'd15) || force_cc;

  wire [6:0] outs = {in_ready, load, add_shift, shift, out_valid, busy, step_err};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete operation: hold = extra DONE cycles before out_ready.
  // With keep_valid set, in_valid stays high through the whole operation.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit keep_valid, input string name);
    logic [6:0]  exp;
    logic [31:0] want;
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    exp_q.push_back({16'd0, a} * {16'd0, b});
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    total++;
    if (outs !== 7'b0100010) begin
      bad++;
      $display("FAIL %s load_cycle: got %b want %b", name, outs, 7'b0100010);
    end
    total++;
    if (cnt !== 4'd0) begin
      bad++;
      $display("FAIL %s counter_start: got %0d want 0", name, cnt);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp = {2'b00, b[i], ~b[i], 1'b0, 1'b1, 1'b0};
      total++;
      if (outs !== exp) begin
        bad++;
        $display("FAIL %s step%0d: got %b want %b", name, i, outs, exp);
      end
    end
    want = '0;
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      if (h == 0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s scoreboard: got empty queue want one entry", name);
        end else begin
          want = exp_q.pop_front();
        end
      end
      total++;
      if (outs !== 7'b0000100) begin
        bad++;
        $display("FAIL %s done_cycle%0d: got %b want %b", name, h, outs, 7'b0000100);
      end
      total++;
      if (prod !== want) begin
        bad++;
        $display("FAIL %s product_cycle%0d: got %h want %h", name, h, prod, want);
      end
      if (h == hold) out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (outs !== 7'b1000000) begin
      bad++;
      $display("FAIL %s idle_after: got %b want %b", name, outs, 7'b1000000);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (outs !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", outs, 7'b1000000);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (outs !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_release_idle: got %b want %b", outs, 7'b1000000);
    end
  endtask

  task automatic test_all_ones();
    do_op(16'h1234, 16'hFFFF, 0, 1'b0, "all_ones");
  endtask

  task automatic test_zero_and_a5a5();
    do_op(16'hBEEF, 16'h0000, 0, 1'b0, "zero_mult");
    do_op(16'hA5A5, 16'h0003, 0, 1'b0, "a5a5_x3");
    total++;
    if (prod !== 32'h0001_F0EF) begin
      bad++;
      $display("FAIL a5a5_literal: got %h want %h", prod, 32'h0001_F0EF);
    end
  endtask

  task automatic test_done_hold();
    do_op(16'h00C3, 16'h8001, 5, 1'b0, "done_hold");
  endtask

  task automatic test_back_to_back();
    do_op(16'h0101, 16'h7F7F, 0, 1'b1, "b2b_first");
    do_op(16'hFFFF, 16'hFFFF, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_calc();
    a_in = 16'h5555;
    b_in = 16'h3C3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midcalc_busy: got %b want 1", busy);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (outs !== 7'b1000000) begin
      bad++;
      $display("FAIL midcalc_reset: got %b want %b", outs, 7'b1000000);
    end
    @(negedge clk);
    reset_n = 1'b1;
    do_op(16'h0F0F, 16'hF00D, 0, 1'b0, "after_reset");
  endtask

  task automatic test_step_check();
    a_in = 16'h0003;
    b_in = 16'h00FF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) force_cc = 1'b1;
    end
    @(negedge clk);
    force_cc = 1'b0;
    total++;
    if (outs !== {6'b000010, STEP_ERR_EXP}) begin
      bad++;
      $display("FAIL stepchk_done: got %b want %b", outs, {6'b000010, STEP_ERR_EXP});
    end
    repeat (3) @(negedge clk);
    total++;
    if (step_err !== STEP_ERR_EXP) begin
      bad++;
      $display("FAIL stepchk_sticky: got %b want %b", step_err, STEP_ERR_EXP);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (outs !== {6'b100000, STEP_ERR_EXP}) begin
      bad++;
      $display("FAIL stepchk_idle: got %b want %b", outs, {6'b100000, STEP_ERR_EXP});
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (step_err !== 1'b0) begin
      bad++;
      $display("FAIL stepchk_reset_clear: got %b want 0", step_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_zero_and_a5a5();
    test_done_hold();
    test_back_to_back();
    test_reset_mid_calc();
    test_step_check();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
